// File: rtl/word_match_detector.sv
// Splits an ASCII stream into words and pulses hit when a whole word matches
// the programmable target word, ignoring letter case.
module word_match_detector #(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_clr,
   input  logic             cfg_wr,
   input  logic [7:0]       cfg_char,
   output logic             cfg_ready,
   output logic [LEN_W-1:0] tgt_len,
   input  logic             ch_valid,
   input  logic [7:0]       ch_data,
   input  logic             ch_last,
   output logic             ch_ready,
   output logic             hit,
   output logic             busy
);

   localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   typedef enum logic [1:0] {IDLE, MATCH, SKIP} state_t;

   state_t           state_reg, state_next;
   logic [LEN_W-1:0] idx_reg, idx_next;
   logic [LEN_W-1:0] tgt_len_reg, tgt_len_next;
   logic             hit_reg, hit_next;
   logic [7:0]       tgt_mem [MAX_LEN];

   logic             cfg_acc, cfg_clr_acc, cfg_wr_acc;
   logic             ch_acc, is_letter, char_eq;
   logic [7:0]       tgt_char;
   logic [LEN_W-1:0] idx_inc;

   assign cfg_ready   = (state_reg == IDLE) && !ch_valid;
   assign cfg_acc     = cfg_ready && (cfg_clr || cfg_wr);
   assign cfg_clr_acc = cfg_ready && cfg_clr;
   assign cfg_wr_acc  = cfg_ready && cfg_wr && !cfg_clr && (tgt_len_reg != MAX_LEN_L);

   assign ch_ready = !cfg_acc;
   assign ch_acc   = ch_valid && ch_ready;

   assign is_letter = ((ch_data >= 8'h41) && (ch_data <= 8'h5A)) ||
                      ((ch_data >= 8'h61) && (ch_data <= 8'h7A));

   // idx is held at 0 outside MATCH, so the same compare serves the first letter.
   assign tgt_char = tgt_mem[idx_reg[ADDR_W-1:0]];
   assign char_eq  = (idx_reg < tgt_len_reg) && ((ch_data | 8'h20) == (tgt_char | 8'h20));
   assign idx_inc  = idx_reg + LEN_W'(1);

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      hit_next   = 1'b0;
      if (ch_acc) begin
         unique case (state_reg)
            IDLE, MATCH: begin
               if (is_letter) begin
                  if (char_eq) begin
                     state_next = MATCH;
                     idx_next   = idx_inc;
                  end else begin
                     state_next = SKIP;
                     idx_next   = '0;
                  end
               end else begin
                  hit_next   = (state_reg == MATCH) && (idx_reg == tgt_len_reg);
                  state_next = IDLE;
                  idx_next   = '0;
               end
            end
            SKIP: begin
               if (!is_letter) state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
               idx_next   = '0;
            end
         endcase
         // A final letter closes its own word.
         if (ch_last) begin
            if ((state_reg != SKIP) && is_letter && char_eq && (idx_inc == tgt_len_reg))
               hit_next = 1'b1;
            state_next = IDLE;
            idx_next   = '0;
         end
      end
   end

   always_comb begin
      tgt_len_next = tgt_len_reg;
      if (cfg_clr_acc)
         tgt_len_next = '0;
      else if (cfg_wr_acc)
         tgt_len_next = tgt_len_reg + LEN_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         tgt_len_reg <= '0;
         hit_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         tgt_len_reg <= tgt_len_next;
         hit_reg     <= hit_next;
      end
   end

   always_ff @(posedge clk) begin
      if (cfg_wr_acc)
         tgt_mem[tgt_len_reg[ADDR_W-1:0]] <= cfg_char;
   end

   assign tgt_len = tgt_len_reg;
   assign hit     = hit_reg;
   assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_word_match_detector.sv
// Directed bench for word_match_detector: target loading, whole-word hits,
// hit timing, config saturation/priority and mid-word reset.
module tb_word_match_detector;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_clr, cfg_wr;
   logic [7:0] cfg_char;
   logic       cfg_ready;
   logic [4:0] tgt_len;
   logic       ch_valid;
   logic [7:0] ch_data;
   logic       ch_last;
   logic       ch_ready;
   logic       hit;
   logic       busy;

   int   tests = 0;
   int   fails = 0;
   int   hit_cnt = 0;
   int   base;
   logic prev_hit = 1'b0;

   always #5 clk = ~clk;

   word_match_detector #(.MAX_LEN(16), .LEN_W(5)) dut (
      .clk(clk), .reset(reset),
      .cfg_clr(cfg_clr), .cfg_wr(cfg_wr), .cfg_char(cfg_char),
      .cfg_ready(cfg_ready), .tgt_len(tgt_len),
      .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last),
      .ch_ready(ch_ready), .hit(hit), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %0d", tag, got);
      end
   endtask

   // Counts hit pulses and checks that no pulse is wider than one cycle.
   always @(negedge clk) begin
      if (hit === 1'b1) begin
         hit_cnt <= hit_cnt + 1;
         check("hit_width", {31'd0, prev_hit}, 32'd0);
      end
      prev_hit <= hit;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [7:0] c);
      cfg_wr = 1'b1;
      cfg_char = c;
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic load(input string s);
      cfg_clr = 1'b1;
      tick();
      cfg_clr = 1'b0;
      for (int i = 0; i < s.len(); i++) cfg_write(s[i]);
   endtask

   task automatic send(input logic [7:0] c, input logic last);
      ch_valid = 1'b1;
      ch_data  = c;
      ch_last  = last;
      tick();
   endtask

   task automatic release_stream();
      ch_valid = 1'b0;
      ch_last  = 1'b0;
      tick();
   endtask

   task automatic stream(input string s, input logic last);
      for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
      release_stream();
   endtask

   initial begin
      string s;
      reset = 1'b0;
      cfg_clr = 1'b0; cfg_wr = 1'b0; cfg_char = 8'h00;
      ch_valid = 1'b0; ch_data = 8'h00; ch_last = 1'b0;
      #12;
      check("rst_hit", {31'd0, hit}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      check("rst_ch_ready", {31'd0, ch_ready}, 32'd1);
      check("rst_tgt_len", {27'd0, tgt_len}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // "the cat sat." : single hit right after the space following "cat"
      load("cat");
      check("t1_tgt_len", {27'd0, tgt_len}, 32'd3);
      base = hit_cnt;
      s = "the cat sat.";
      for (int i = 0; i < s.len(); i++) begin
         send(s[i], 1'b0);
         check($sformatf("t1_hit_after_%0d", i), {31'd0, hit}, (i == 7) ? 32'd1 : 32'd0);
      end
      release_stream();
      check("t1_hits", hit_cnt - base, 32'd1);

      // case folding and whole-word rules
      base = hit_cnt;
      stream("Cat CAT cats ca cat.", 1'b1);
      check("t2_hits", hit_cnt - base, 32'd3);
      check("t2_busy_end", {31'd0, busy}, 32'd0);

      // ch_last on a letter
      base = hit_cnt;
      stream("xcat", 1'b1);
      check("t3_xcat_hits", hit_cnt - base, 32'd0);
      base = hit_cnt;
      send("c", 1'b0);
      send("a", 1'b0);
      send("t", 1'b1);
      check("t3_hit_last", {31'd0, hit}, 32'd1);
      check("t3_idle_last", {31'd0, busy}, 32'd0);
      release_stream();
      check("t3_cat_hits", hit_cnt - base, 32'd1);

      // config while busy, saturation, clear priority
      send("a", 1'b0);
      ch_valid = 1'b0;
      cfg_wr = 1'b1;
      cfg_char = "z";
      #1;
      check("t4_busy", {31'd0, busy}, 32'd1);
      check("t4_cfg_ready_busy", {31'd0, cfg_ready}, 32'd0);
      check("t4_ch_ready_busy", {31'd0, ch_ready}, 32'd1);
      tick();
      cfg_wr = 1'b0;
      check("t4_len_busy_wr", {27'd0, tgt_len}, 32'd3);
      send(" ", 1'b0);
      ch_valid = 1'b0;
      cfg_wr = 1'b1;
      cfg_char = "q";
      #1;
      check("t4_ch_ready_cfg", {31'd0, ch_ready}, 32'd0);
      tick();
      cfg_wr = 1'b0;
      check("t4_len_wr0", {27'd0, tgt_len}, 32'd4);
      for (int i = 1; i < 17; i++) begin
         cfg_write("q");
         check($sformatf("t4_len_wr%0d", i), {27'd0, tgt_len}, (i + 4 > 16) ? 32'd16 : 32'(i + 4));
      end
      cfg_clr = 1'b1;
      cfg_wr = 1'b1;
      cfg_char = "q";
      tick();
      cfg_clr = 1'b0;
      cfg_wr = 1'b0;
      check("t4_clr_beats_wr", {27'd0, tgt_len}, 32'd0);
      base = hit_cnt;
      stream("a b.", 1'b1);
      check("t4_empty_hits", hit_cnt - base, 32'd0);

      // async reset mid-word
      load("dog");
      send("d", 1'b0);
      send("o", 1'b0);
      check("t5_busy_mid", {31'd0, busy}, 32'd1);
      ch_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_hit", {31'd0, hit}, 32'd0);
      check("t5_rst_tgt_len", {27'd0, tgt_len}, 32'd0);
      check("t5_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      check("t5_rst_ch_ready", {31'd0, ch_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();
      base = hit_cnt;
      stream("g ", 1'b0);
      check("t5_hits", hit_cnt - base, 32'd0);

      // back-to-back words: hits on cycles 4, 8 and 12
      load("dog");
      base = hit_cnt;
      s = "dog,dog;dog.";
      for (int i = 0; i < s.len(); i++) begin
         send(s[i], i == s.len() - 1);
         check($sformatf("t6_hit_cycle_%0d", i + 1), {31'd0, hit},
               (i == 3 || i == 7 || i == 11) ? 32'd1 : 32'd0);
      end
      release_stream();
      check("t6_hits", hit_cnt - base, 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
